// File: rtl/tbl_search_seq.sv
// Binomial-table row search: returns the last row of column `col` whose cell qualifies
// against `num`, resolving one row bit per cycle behind valid/ready handshakes.
module tbl_search_seq #(
    parameter int unsigned NUM_WIDTH   = 10,
    parameter int unsigned ROWS_NUM    = 13,
    parameter int unsigned COLS_NUM    = 13,
    parameter int unsigned VALUE_WIDTH = 10,
    parameter int unsigned COL_WIDTH   = 4,
    parameter int unsigned ROW_WIDTH   = 4,
    parameter int unsigned STRICT      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_WIDTH-1:0]   num,
    input  logic [COL_WIDTH-1:0]   col,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ROW_WIDTH-1:0]   row,
    output logic [VALUE_WIDTH-1:0] val,
    output logic [NUM_WIDTH-1:0]   rem,
    output logic                   hit,
    output logic                   err
);

    localparam int unsigned CmpWidth = (NUM_WIDTH > VALUE_WIDTH) ? NUM_WIDTH : VALUE_WIDTH;
    localparam int unsigned RowSpan  = 2 ** ROW_WIDTH;
    localparam int unsigned ColSpan  = 2 ** COL_WIDTH;
    localparam longint unsigned MaxVal = (64'd1 << VALUE_WIDTH) - 64'd1;

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    function automatic longint unsigned binom(input int unsigned r, input int unsigned c);
        longint unsigned res;
        res = 64'd1;
        for (int unsigned i = 0; i < c; i++) begin
            if (i < r) res = res * 64'(r - i) / 64'(i + 1);
            else res = 64'd0;
        end
        return res;
    endfunction

    function automatic logic qualifies(input logic ok, input logic [VALUE_WIDTH-1:0] v,
                                       input logic [NUM_WIDTH-1:0] n);
        logic [CmpWidth-1:0] ve;
        logic [CmpWidth-1:0] ne;
        ve = CmpWidth'(v);
        ne = CmpWidth'(n);
        if (!ok) return 1'b0;
        return (STRICT != 0) ? (ve < ne) : (ve <= ne);
    endfunction

    // Padded to the full index space; cells outside the table or saturated never qualify.
    logic [VALUE_WIDTH-1:0] cell_val [RowSpan][ColSpan];
    logic                   cell_ok  [RowSpan][ColSpan];

    for (genvar r = 0; r < RowSpan; r++) begin : g_row
        for (genvar c = 0; c < ColSpan; c++) begin : g_col
            localparam longint unsigned Raw = binom(r, c);
            localparam bit Ok = (r < ROWS_NUM) && (c < COLS_NUM) && (Raw <= MaxVal);
            assign cell_val[r][c] = VALUE_WIDTH'(Raw);
            assign cell_ok[r][c]  = Ok;
        end
    end

    state_e                 state_q, state_d;
    logic [NUM_WIDTH-1:0]   num_q, num_d;
    logic [COL_WIDTH-1:0]   col_q, col_d;
    logic [ROW_WIDTH-1:0]   best_q, best_d;
    logic [ROW_WIDTH-1:0]   k_q, k_d;
    logic                   s_hit_q, s_hit_d;
    logic                   s_err_q, s_err_d;
    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic [VALUE_WIDTH-1:0] val_q, val_d;
    logic [NUM_WIDTH-1:0]   rem_q, rem_d;
    logic                   hit_q, hit_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   col_err;
    logic                   row0_qual;
    logic [ROW_WIDTH-1:0]   probe;
    logic                   probe_hit;
    logic [ROW_WIDTH-1:0]   best_next;
    logic [VALUE_WIDTH-1:0] best_val;
    logic [NUM_WIDTH-1:0]   rem_calc;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign col_err   = !(32'(col) < COLS_NUM);
    assign row0_qual = qualifies(cell_ok[0][col], cell_val[0][col], num);

    assign probe     = best_q | (ROW_WIDTH'(1) << k_q);
    assign probe_hit = s_hit_q && (32'(probe) < ROWS_NUM)
                       && qualifies(cell_ok[probe][col_q], cell_val[probe][col_q], num_q);
    assign best_next = probe_hit ? probe : best_q;
    assign best_val  = cell_val[best_next][col_q];
    assign rem_calc  = NUM_WIDTH'(CmpWidth'(num_q) - CmpWidth'(best_val));

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        col_d   = col_q;
        best_d  = best_q;
        k_d     = k_q;
        s_hit_d = s_hit_q;
        s_err_d = s_err_q;
        row_d   = row_q;
        val_d   = val_q;
        rem_d   = rem_q;
        hit_d   = hit_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StSearch;
            end
            StSearch: begin
                best_d = best_next;
                k_d    = k_q - ROW_WIDTH'(1);
                if (k_q == '0) begin
                    state_d = StDone;
                    hit_d   = s_hit_q;
                    err_d   = s_err_q;
                    if (s_hit_q) begin
                        row_d = best_next;
                        val_d = best_val;
                        rem_d = rem_calc;
                    end else begin
                        row_d = '0;
                        val_d = '0;
                        rem_d = num_q;
                    end
                end
            end
            StDone: begin
                if (out_ready) state_d = accept ? StSearch : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Accept can only happen in StIdle or StDone, so it never collides with a search step.
        if (accept) begin
            num_d   = num;
            col_d   = col;
            best_d  = '0;
            k_d     = ROW_WIDTH'(ROW_WIDTH - 1);
            s_err_d = col_err;
            s_hit_d = row0_qual && !col_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            num_q   <= '0;
            col_q   <= '0;
            best_q  <= '0;
            k_q     <= '0;
            s_hit_q <= 1'b0;
            s_err_q <= 1'b0;
            row_q   <= '0;
            val_q   <= '0;
            rem_q   <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            col_q   <= col_d;
            best_q  <= best_d;
            k_q     <= k_d;
            s_hit_q <= s_hit_d;
            s_err_q <= s_err_d;
            row_q   <= row_d;
            val_q   <= val_d;
            rem_q   <= rem_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign row       = row_q;
    assign val       = val_q;
    assign rem       = rem_q;
    assign hit       = hit_q;
    assign err       = err_q;

endmodule

// File: tb/tb_tbl_search_seq.sv
// Scoreboard bench: two instances (STRICT=0 and STRICT=1) driven with directed requests.
module tb_tbl_search_seq;

    typedef struct packed {
        logic [3:0] row;
        logic [9:0] val;
        logic [9:0] rem;
        logic       hit;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [9:0] num       [2];
    logic [3:0] col       [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [3:0] row       [2];
    logic [9:0] val       [2];
    logic [9:0] rem       [2];
    logic       hit       [2];
    logic       err       [2];

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    tbl_search_seq #(.STRICT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .num(num[0]), .col(col[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .row(row[0]), .val(val[0]), .rem(rem[0]), .hit(hit[0]), .err(err[0])
    );

    tbl_search_seq #(.STRICT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .num(num[1]), .col(col[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .row(row[1]), .val(val[1]), .rem(rem[1]), .hit(hit[1]), .err(err[1])
    );

    function automatic exp_t mk(input logic [3:0] r, input logic [9:0] v, input logic [9:0] m,
                                input logic h, input logic e);
        exp_t x;
        x.row = r; x.val = v; x.rem = m; x.hit = h; x.err = e;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_out(input int d);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk($sformatf("unexpected_result_dut%0d", d), 32'd1, 32'd0);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("dut%0d_row", d), 32'(row[d]), 32'(e.row));
        chk($sformatf("dut%0d_val", d), 32'(val[d]), 32'(e.val));
        chk($sformatf("dut%0d_rem", d), 32'(rem[d]), 32'(e.rem));
        chk($sformatf("dut%0d_hit", d), 32'(hit[d]), 32'(e.hit));
        chk($sformatf("dut%0d_err", d), 32'(err[d]), 32'(e.err));
    endtask

    // Monitor: a result is consumed at the next rising edge whenever valid and ready are high.
    always @(negedge clk) begin
        if (!rst && out_valid[0] && out_ready[0]) check_out(0);
        if (!rst && out_valid[1] && out_ready[1]) check_out(1);
    end

    task automatic send(input int d, input logic [9:0] n, input logic [3:0] c, input exp_t e,
                        input bit push, output int waited);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready[d] && t < 40) begin
            @(negedge clk);
            t++;
        end
        waited = t;
        if (!in_ready[d]) begin
            chk($sformatf("accept_timeout_dut%0d", d), 32'd0, 32'd1);
            return;
        end
        if (push) begin
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        in_valid[d] = 1'b1;
        num[d]      = n;
        col[d]      = c;
        @(posedge clk);
        #1 in_valid[d] = 1'b0;
    endtask

    // Called just after the accept edge: out_valid must rise only after the 4th following edge.
    task automatic lat(input int d);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("latency_dut%0d_cyc%0d", d, i), 32'(out_valid[d]), (i == 4) ? 32'd1 : 32'd0);
            if (i < 4) chk($sformatf("busy_ready_dut%0d", d), 32'(in_ready[d]), 32'd0);
        end
    endtask

    task automatic run_one(input int d, input logic [9:0] n, input logic [3:0] c, input exp_t e);
        int w;
        send(d, n, c, e, 1'b1, w);
        lat(d);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int w;
        int t;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            num[d]       = '0;
            col[d]       = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_out_valid", 32'(out_valid[d]), 32'd0);
            chk("reset_in_ready", 32'(in_ready[d]), 32'd1);
            chk("reset_row", 32'(row[d]), 32'd0);
            chk("reset_val", 32'(val[d]), 32'd0);
            chk("reset_rem", 32'(rem[d]), 32'd0);
            chk("reset_hit", 32'(hit[d]), 32'd0);
            chk("reset_err", 32'(err[d]), 32'd0);
        end

        // Non-strict directed vectors
        run_one(0, 10'd40,   4'd2,  mk(4'd9,  10'd36,  10'd4,    1'b1, 1'b0));
        run_one(0, 10'd0,    4'd3,  mk(4'd2,  10'd0,   10'd0,    1'b1, 1'b0));
        run_one(0, 10'd1023, 4'd1,  mk(4'd12, 10'd12,  10'd1011, 1'b1, 1'b0));
        run_one(0, 10'd0,    4'd0,  mk(4'd0,  10'd0,   10'd0,    1'b0, 1'b0));
        run_one(0, 10'd5,    4'd13, mk(4'd0,  10'd0,   10'd5,    1'b0, 1'b1));
        run_one(0, 10'd36,   4'd2,  mk(4'd9,  10'd36,  10'd0,    1'b1, 1'b0));
        run_one(0, 10'd1,    4'd12, mk(4'd12, 10'd1,   10'd0,    1'b1, 1'b0));
        run_one(0, 10'd1023, 4'd6,  mk(4'd12, 10'd924, 10'd99,   1'b1, 1'b0));
        run_one(0, 10'd9,    4'd15, mk(4'd0,  10'd0,   10'd9,    1'b0, 1'b1));

        // Strict vectors
        run_one(1, 10'd36, 4'd2, mk(4'd8, 10'd28, 10'd8, 1'b1, 1'b0));
        run_one(1, 10'd1,  4'd0, mk(4'd0, 10'd0,  10'd1, 1'b0, 1'b0));
        run_one(1, 10'd0,  4'd3, mk(4'd0, 10'd0,  10'd0, 1'b0, 1'b0));
        run_one(1, 10'd1,  4'd3, mk(4'd2, 10'd0,  10'd1, 1'b1, 1'b0));

        // Back-pressure: result must hold while out_ready is low
        out_ready[0] = 1'b0;
        send(0, 10'd40, 4'd2, mk(4'd9, 10'd36, 10'd4, 1'b1, 1'b0), 1'b1, w);
        t = 0;
        while (!out_valid[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_rises", 32'(out_valid[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid[0]), 32'd1);
            chk("bp_hold_in_ready", 32'(in_ready[0]), 32'd0);
            chk("bp_hold_row", 32'(row[0]), 32'd9);
            chk("bp_hold_val", 32'(val[0]), 32'd36);
            chk("bp_hold_rem", 32'(rem[0]), 32'd4);
        end
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        send(0, 10'd1023, 4'd1, mk(4'd12, 10'd12, 10'd1011, 1'b1, 1'b0), 1'b1, w);
        chk("bp_same_edge_accept", 32'(w), 32'd0);
        lat(0);

        // Reset two cycles into a search discards it
        send(0, 10'd40, 4'd2, mk(4'd0, 10'd0, 10'd0, 1'b0, 1'b0), 1'b0, w);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", 32'(in_ready[0]), 32'd1);
        chk("rst_mid_row", 32'(row[0]), 32'd0);
        chk("rst_mid_val", 32'(val[0]), 32'd0);
        chk("rst_mid_rem", 32'(rem[0]), 32'd0);
        chk("rst_mid_hit", 32'(hit[0]), 32'd0);
        chk("rst_mid_err", 32'(err[0]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("rst_mid_out_valid", 32'(out_valid[0]), 32'd0);
            @(negedge clk);
        end
        run_one(0, 10'd40, 4'd2, mk(4'd9, 10'd36, 10'd4, 1'b1, 1'b0));

        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
